fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter TRAP_PC, default 32'h0000_0100, meaning PC loaded on misaligned redirect.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pc_f  output  32  fetch address driven to instruction memory.
REQ-006 SHALL have port instr_f  input  32  instruction word returned combinationally for pc_f.
REQ-007 SHALL have port stall_f  input  1  hold PC register.
REQ-008 SHALL have port stall_d  input  1  hold IF/ID register.
REQ-009 SHALL have port flush_d  input  1  load bubble into IF/ID.
REQ-010 SHALL have port pc_src_e  input  1  taken branch/jump redirect from EX.
REQ-011 SHALL have port pc_target_e  input  32  redirect target address.
REQ-012 SHALL have ports instr_d / pc_d / pc_plus4_d  output  32 each  IF/ID instruction, its PC, PC+4.
REQ-013 SHALL have port valid_d  output  1  IF/ID holds a real instruction.
REQ-014 SHALL have port misalign_err  output  1  one-cycle pulse on misaligned redirect.
REQ-015 SHALL have port halted  output  1  high while FSM is in HALT.
REQ-016 SHALL have port fetch_count  output  32  count of valid instructions loaded into IF/ID.

Function
REQ-017 FSM SHALL have states RUN and HALT; halted = (state == HALT).
REQ-018 RUN->HALT SHALL occur on an edge where valid_d=1, instr_d=32'h0010_0073 (EBREAK), flush_d=0, pc_src_e=0; HALT exits only via reset.
REQ-019 Next PC priority in RUN SHALL be: pc_src_e -> pc_target_e (or TRAP_PC if misaligned); else stall_f -> hold; else pc_f+4.
REQ-020 pc_src_e SHALL override stall_f.
REQ-021 In HALT, pc_f SHALL hold; pc_src_e, stall_f ignored.
REQ-022 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-023 Misaligned redirect (pc_src_e=1, pc_target_e[1:0]!=0) SHALL load pc_f=TRAP_PC and assert misalign_err for exactly the following cycle.
REQ-024 IF/ID update priority SHALL be: flush_d or pc_src_e -> bubble; else stall_d -> hold; else HALT -> bubble; else load {instr_f, pc_f, pc_f+4, valid=1}.
REQ-025 Bubble SHALL be instr_d=32'h0000_0013 (NOP), pc_d=0, pc_plus4_d=0, valid_d=0.
REQ-026 Redirect SHALL bubble IF/ID internally even when flush_d=0.
REQ-027 fetch_count SHALL increment by 1 on each load-path edge of REQ-024, wrapping 2^32-1 -> 0.
REQ-028 Latency: instruction at pc_f SHALL appear on instr_d one edge after it is presented, absent stall/flush.

Reset
REQ-029 On reset edge: pc_f=RESET_PC, IF/ID=bubble, misalign_err=0, fetch_count=0, state=RUN; reset overrides all inputs.
REQ-030 Reset asserted mid-stall, mid-redirect or in HALT SHALL produce identical state to REQ-029 on next edge.

Verification
REQ-031 Release reset, no stalls, memory words W0,W1,W2 -> pc_f 0,4,8; instr_d W0,W1 on cycles 1,2; pc_plus4_d 4,8; fetch_count 2 after cycle 2.
REQ-032 stall_f=stall_d=1 for 3 cycles at pc_f=8 -> pc_f, instr_d, fetch_count unchanged; resume at 12.
REQ-033 pc_src_e=1, pc_target_e=0x40, stall_f=1 same cycle -> next pc_f=0x40, valid_d=0, instr_d=0x13.
REQ-034 pc_src_e=1, pc_target_e=0x42 -> pc_f=0x100, misalign_err=1 one cycle, valid_d=0.
REQ-035 EBREAK reaches IF/ID unflushed -> halted=1 next edge, pc_f frozen, valid_d=0 thereafter; reset returns pc_f=0, halted=0.
REQ-036 pc_f=0xFFFF_FFFC, no stall -> next pc_f=0; fetch_count preset near 2^32-1 wraps to 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a RUN/HALT
// controller that stops fetching once an EBREAK reaches decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_f,
    input  logic [31:0] instr_f,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        misalign_err,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic {RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] pc_plus4;
    logic        target_misaligned;

    assign pc_plus4          = pc_f_q + 32'd4;
    assign target_misaligned = pc_src_e && (pc_target_e[1:0] != 2'b00);

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned -- that is what keeps this block from inferring latches.
    always_comb begin
        state_d       = state_q;
        pc_f_d        = pc_f_q;
        misalign_d    = 1'b0;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc4_d      = id_pc4_q;
        id_valid_d    = id_valid_q;
        fetch_count_d = fetch_count_q;

        if (state_q == RUN) begin
            // A redirect wins over a fetch stall; misaligned targets trap.
            if (pc_src_e) begin
                pc_f_d     = target_misaligned ? TRAP_PC : pc_target_e;
                misalign_d = target_misaligned;
            end else if (!stall_f) begin
                pc_f_d = pc_plus4;
            end

            if (id_valid_q && id_instr_q == EBREAK_INSTR && !flush_d && !pc_src_e)
                state_d = HALT;
        end

        if (flush_d || pc_src_e || (!stall_d && state_q == HALT)) begin
            id_instr_d = NOP_INSTR;
            id_pc_d    = 32'h0;
            id_pc4_d   = 32'h0;
            id_valid_d = 1'b0;
        end else if (!stall_d) begin
            id_instr_d    = instr_f;
            id_pc_d       = pc_f_q;
            id_pc4_d      = pc_plus4;
            id_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_f_q        <= RESET_PC;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= 32'h0;
            id_pc4_q      <= 32'h0;
            id_valid_q    <= 1'b0;
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_f_q        <= pc_f_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc4_q      <= id_pc4_d;
            id_valid_q    <= id_valid_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc_f         = pc_f_q;
    assign instr_d      = id_instr_q;
    assign pc_d         = id_pc_q;
    assign pc_plus4_d   = id_pc4_q;
    assign valid_d      = id_valid_q;
    assign misalign_err = misalign_q;
    assign halted       = (state_q == HALT);
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed per-cycle vectors push hand-computed
// post-edge state; a monitor pops and compares one record after every rising edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EBK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f, instr_f, pc_target_e;
    logic        stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] instr_d, pc_d, pc_plus4_d, fetch_count;
    logic        valid_d, misalign_err, halted;

    typedef struct {
        int          step;
        logic [31:0] pc, ins, pcd, p4, cnt;
        logic        v, m, h;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   step_n = 0;

    always #5 clk = ~clk;

    // Instruction memory: EBREAK at 0x60, otherwise a word tagged with its address.
    function automatic logic [31:0] w(input logic [31:0] a);
        if (a == 32'h60) return EBK;
        return {16'hC0DE, a[15:0]};
    endfunction

    assign instr_f = w(pc_f);

    fetch_stage dut (
        .clk(clk), .reset(reset), .pc_f(pc_f), .instr_f(instr_f),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .valid_d(valid_d), .misalign_err(misalign_err), .halted(halted),
        .fetch_count(fetch_count)
    );

    task automatic check(input int step, input string name,
                         input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL step %0d %s: got %h want %h", step, name, got, want);
        end
    endtask

    task automatic cyc(input logic rs, sf, sd, fl, ps, input logic [31:0] tg,
                       input logic [31:0] e_pc, e_ins, e_pcd, e_p4,
                       input logic e_v, e_m, e_h, input logic [31:0] e_cnt);
        exp_t e;
        @(negedge clk);
        reset = rs; stall_f = sf; stall_d = sd; flush_d = fl;
        pc_src_e = ps; pc_target_e = tg;
        e.step = step_n; e.pc = e_pc; e.ins = e_ins; e.pcd = e_pcd; e.p4 = e_p4;
        e.v = e_v; e.m = e_m; e.h = e_h; e.cnt = e_cnt;
        q.push_back(e);
        step_n++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check(e.step, "pc_f",         pc_f,                  e.pc);
                check(e.step, "instr_d",      instr_d,               e.ins);
                check(e.step, "pc_d",         pc_d,                  e.pcd);
                check(e.step, "pc_plus4_d",   pc_plus4_d,            e.p4);
                check(e.step, "valid_d",      {31'b0, valid_d},      {31'b0, e.v});
                check(e.step, "misalign_err", {31'b0, misalign_err}, {31'b0, e.m});
                check(e.step, "halted",       {31'b0, halted},       {31'b0, e.h});
                check(e.step, "fetch_count",  fetch_count,           e.cnt);
            end
        end
    end

    initial begin : driver
        reset = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        pc_src_e = 1'b0; pc_target_e = 32'h0;

        //   rs sf sd fl ps target          pc            instr_d         pc_d          pc_plus4_d    v m h count
        cyc(1, 0, 0, 0, 0, 32'h0,         32'h0,        NOP,            32'h0,        32'h0,        0,0,0, 32'd0);
        cyc(1, 0, 0, 0, 0, 32'h0,         32'h0,        NOP,            32'h0,        32'h0,        0,0,0, 32'd0);
        // Straight-line fetch
        cyc(0, 0, 0, 0, 0, 32'h0,         32'h4,        w(32'h0),       32'h0,        32'h4,        1,0,0, 32'd1);
        cyc(0, 0, 0, 0, 0, 32'h0,         32'h8,        w(32'h4),       32'h4,        32'h8,        1,0,0, 32'd2);
        // Full stall for three cycles at pc 8, then resume
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 1, 0, 0, 32'h0,     32'h8,        w(32'h4),       32'h4,        32'h8,        1,0,0, 32'd2);
        cyc(0, 0, 0, 0, 0, 32'h0,         32'hC,        w(32'h8),       32'h8,        32'hC,        1,0,0, 32'd3);
        // Redirect beats stall_f
        cyc(0, 1, 0, 0, 1, 32'h40,        32'h40,       NOP,            32'h0,        32'h0,        0,0,0, 32'd3);
        cyc(0, 0, 0, 0, 0, 32'h0,         32'h44,       w(32'h40),      32'h40,       32'h44,       1,0,0, 32'd4);
        // flush_d alone bubbles decode but PC advances
        cyc(0, 0, 0, 1, 0, 32'h0,         32'h48,       NOP,            32'h0,        32'h0,        0,0,0, 32'd4);
        cyc(0, 0, 0, 0, 0, 32'h0,         32'h4C,       w(32'h48),      32'h48,       32'h4C,       1,0,0, 32'd5);
        // stall_d alone holds IF/ID while PC advances
        cyc(0, 0, 1, 0, 0, 32'h0,         32'h50,       w(32'h48),      32'h48,       32'h4C,       1,0,0, 32'd5);
        // Misaligned redirect traps and pulses misalign_err for one cycle
        cyc(0, 0, 0, 0, 1, 32'h42,        32'h100,      NOP,            32'h0,        32'h0,        0,1,0, 32'd5);
        cyc(0, 0, 0, 0, 0, 32'h0,         32'h104,      w(32'h100),     32'h100,      32'h104,      1,0,0, 32'd6);
        // Redirect beats stall_d
        cyc(0, 0, 1, 0, 1, 32'h5C,        32'h5C,       NOP,            32'h0,        32'h0,        0,0,0, 32'd6);
        cyc(0, 0, 0, 0, 0, 32'h0,         32'h60,       w(32'h5C),      32'h5C,       32'h60,       1,0,0, 32'd7);
        // EBREAK enters decode, then halts on the following edge
        cyc(0, 0, 0, 0, 0, 32'h0,         32'h64,       EBK,            32'h60,       32'h64,       1,0,0, 32'd8);
        cyc(0, 0, 0, 0, 0, 32'h0,         32'h68,       w(32'h64),      32'h64,       32'h68,       1,0,1, 32'd9);
        // In HALT: misaligned redirect does not move PC or raise misalign_err
        cyc(0, 0, 0, 0, 1, 32'h202,       32'h68,       NOP,            32'h0,        32'h0,        0,0,1, 32'd9);
        cyc(0, 0, 0, 0, 0, 32'h0,         32'h68,       NOP,            32'h0,        32'h0,        0,0,1, 32'd9);
        // Reset from HALT with conflicting inputs
        cyc(1, 1, 1, 0, 1, 32'h80,        32'h0,        NOP,            32'h0,        32'h0,        0,0,0, 32'd0);
        cyc(0, 0, 0, 0, 0, 32'h0,         32'h4,        w(32'h0),       32'h0,        32'h4,        1,0,0, 32'd1);
        // Reset mid-stall and mid-misaligned-redirect
        cyc(1, 1, 1, 0, 0, 32'h0,         32'h0,        NOP,            32'h0,        32'h0,        0,0,0, 32'd0);
        cyc(1, 0, 0, 0, 1, 32'h42,        32'h0,        NOP,            32'h0,        32'h0,        0,0,0, 32'd0);
        // PC wrap at the top of the address space
        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP,           32'h0,        32'h0,        0,0,0, 32'd0);

        // Preset the fetch counter just below its wrap point
        @(negedge clk);
        force dut.fetch_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_count_q;

        cyc(0, 0, 0, 0, 0, 32'h0,         32'h0,        w(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0,     1,0,0, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 0, 0, 32'h0,         32'h4,        w(32'h0),       32'h0,        32'h4,        1,0,0, 32'h0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: got %0d pending records want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
